// File: rtl/spi_bridge_ctrl.sv
// Sequencer between the bridge FIFOs and the SPI master: fetch one command,
// run one frame with watchdog, push read data, then hold the CS gap.
module spi_bridge_ctrl #(
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic             enable,
  input  logic [40:0]      TxFIFO_dout,
  input  logic             TxFIFO_empty,
  output logic             TxFIFO_rd_en,
  output logic [31:0]      RxFIFO_din,
  output logic             RxFIFO_wr_en,
  input  logic             RxFIFO_full,
  output logic             spi_start,
  output logic [8:0]       spi_hdr,
  output logic [31:0]      spi_wdata,
  input  logic             spi_done,
  input  logic [31:0]      spi_rdata,
  output logic             spi_abort,
  output logic             busy,
  output logic             err_timeout,
  input  logic             err_clr,
  output logic [CNT_W-1:0] txn_count
);
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int GW = $clog2(GAP_CYCLES) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_START, S_WAIT, S_PUSH, S_GAP
  } state_t;

  state_t        state;
  logic [TW-1:0] wdog;
  logic [GW-1:0] gap_cnt;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state        <= S_IDLE;
      TxFIFO_rd_en <= 1'b0;
      RxFIFO_wr_en <= 1'b0;
      spi_start    <= 1'b0;
      spi_abort    <= 1'b0;
      spi_hdr      <= '0;
      spi_wdata    <= '0;
      RxFIFO_din   <= '0;
      busy         <= 1'b0;
      err_timeout  <= 1'b0;
      txn_count    <= '0;
      wdog         <= '0;
      gap_cnt      <= '0;
    end else begin
      TxFIFO_rd_en <= 1'b0;
      RxFIFO_wr_en <= 1'b0;
      spi_start    <= 1'b0;
      spi_abort    <= 1'b0;
      // a timeout set below overrides this clear
      if (err_clr) err_timeout <= 1'b0;
      case (state)
        S_IDLE: if (enable && !TxFIFO_empty) begin
          TxFIFO_rd_en <= 1'b1;
          busy         <= 1'b1;
          state        <= S_FETCH;
        end
        S_FETCH: state <= S_START;
        // popped word is on TxFIFO_dout the cycle after the strobe, i.e. now
        S_START: begin
          spi_hdr   <= TxFIFO_dout[40:32];
          spi_wdata <= TxFIFO_dout[31:0];
          spi_start <= 1'b1;
          wdog      <= '0;
          state     <= S_WAIT;
        end
        S_WAIT: begin
          if (spi_done) begin
            if (spi_hdr[8]) begin
              txn_count <= txn_count + 1'b1;
              gap_cnt   <= '0;
              state     <= S_GAP;
            end else begin
              RxFIFO_din <= spi_rdata;
              state      <= S_PUSH;
            end
          end else if (wdog == TW'(TIMEOUT_CYCLES - 1)) begin
            spi_abort   <= 1'b1;
            err_timeout <= 1'b1;
            if (spi_hdr[8]) begin
              txn_count <= txn_count + 1'b1;
              gap_cnt   <= '0;
              state     <= S_GAP;
            end else begin
              RxFIFO_din <= 32'hFFFF_FFFF;
              state      <= S_PUSH;
            end
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        S_PUSH: if (!RxFIFO_full) begin
          RxFIFO_wr_en <= 1'b1;
          txn_count    <= txn_count + 1'b1;
          gap_cnt      <= '0;
          state        <= S_GAP;
        end
        S_GAP: begin
          if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_bridge_ctrl.sv
// Bench for spi_bridge_ctrl: FIFO/SPI-slave models plus a frame-level
// scoreboard predicting fetch order, frame outcome, read data and counts.
module tb_spi_bridge_ctrl;
  localparam int GAP = 4, TMO = 16, CW = 4;

  logic HCLK = 1'b0, HRESET = 1'b1, enable = 1'b0, err_clr = 1'b0;
  logic TxFIFO_empty = 1'b1, RxFIFO_full = 1'b0, spi_done = 1'b0;
  logic [40:0] TxFIFO_dout = '0;
  logic [31:0] spi_rdata = '0;
  logic TxFIFO_rd_en, RxFIFO_wr_en, spi_start, spi_abort, busy, err_timeout;
  logic [31:0] RxFIFO_din, spi_wdata;
  logic [8:0]  spi_hdr;
  logic [CW-1:0] txn_count;

  spi_bridge_ctrl #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO), .CNT_W(CW)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .enable(enable),
    .TxFIFO_dout(TxFIFO_dout), .TxFIFO_empty(TxFIFO_empty), .TxFIFO_rd_en(TxFIFO_rd_en),
    .RxFIFO_din(RxFIFO_din), .RxFIFO_wr_en(RxFIFO_wr_en), .RxFIFO_full(RxFIFO_full),
    .spi_start(spi_start), .spi_hdr(spi_hdr), .spi_wdata(spi_wdata),
    .spi_done(spi_done), .spi_rdata(spi_rdata), .spi_abort(spi_abort),
    .busy(busy), .err_timeout(err_timeout), .err_clr(err_clr), .txn_count(txn_count));

  always #5 HCLK = ~HCLK;

  int n_cmp = 0, n_err = 0;
  int cyc = 0;
  logic full_smp = 1'b0;
  always @(posedge HCLK) begin
    cyc++;
    full_smp = RxFIFO_full;
  end

  // stimulus queues (command, response delay (-1 = never), read data)
  logic [40:0] txq[$], isq[$];
  int          dq[$], idq[$];
  logic [31:0] rq[$], irq[$], exp_rx[$];
  logic [40:0] pend_val, fcmd;
  logic [31:0] frd, last_rx, last_wdata;
  logic [8:0]  last_hdr;
  bit pend = 0, infl = 0, fto = 0, exp_err = 0;
  int cnt = 0, fd = 0, exp_txn = 0;
  int n_fetch = 0, n_start = 0, n_done = 0, n_abort = 0, n_push = 0;
  int rd_cyc = 0, start_cyc = 0, done_cyc = 0, abort_cyc = 0, push_cyc = 0, last_end = -1;

  always @(negedge HCLK) begin
    spi_done  = 1'b0;
    spi_rdata = $urandom;
    if (pend) begin
      TxFIFO_dout = pend_val;
      pend = 0;
    end
    if (HRESET) begin
      isq.delete(); idq.delete(); irq.delete(); exp_rx.delete();
      infl = 0; exp_txn = 0; exp_err = 0; last_end = -1;
    end else begin
      if (TxFIFO_rd_en) begin
        n_cmp++;
        if (txq.size() == 0) begin
          n_err++; $display("FAIL rd_en_while_empty: got rd_en=1 want 0 at cyc %0d", cyc);
        end else begin
          pend_val = txq.pop_front(); pend = 1;
          TxFIFO_dout = {9'($urandom), $urandom};
          isq.push_back(pend_val); idq.push_back(dq.pop_front()); irq.push_back(rq.pop_front());
          n_fetch++;
          if (last_end >= 0) begin
            n_cmp++;
            if (cyc - last_end < GAP + 2) begin
              n_err++; $display("FAIL cs_gap: got %0d want >= %0d", cyc - last_end, GAP + 2);
            end
          end
          rd_cyc = cyc;
        end
      end
      if (spi_abort) begin
        n_cmp++; n_abort++;
        if (!(infl && fto && cyc == start_cyc + TMO)) begin
          n_err++; $display("FAIL abort_timing: got abort at cyc %0d want %0d (expected=%0d)",
                            cyc, start_cyc + TMO, infl && fto);
        end
        infl = 0; abort_cyc = cyc; last_end = cyc - 1;
      end
      if (spi_start) begin
        n_start++; n_cmp++;
        if (isq.size() == 0) begin
          n_err++; $display("FAIL start_without_fetch: got spi_start=1 want 0");
        end else begin
          fcmd = isq.pop_front(); fd = idq.pop_front(); frd = irq.pop_front();
          n_cmp += 2;
          if ({spi_hdr, spi_wdata} !== fcmd) begin
            n_err++; $display("FAIL frame_cmd: got %h want %h", {spi_hdr, spi_wdata}, fcmd);
          end
          if (cyc - rd_cyc != 2) begin
            n_err++; $display("FAIL start_latency: got %0d want 2", cyc - rd_cyc);
          end
          infl = 1; start_cyc = cyc;
          fto = (fd < 0 || fd >= TMO);
          cnt = fto ? -1 : fd;
          exp_txn++;
          if (fto) exp_err = 1;
          if (!fcmd[40]) exp_rx.push_back(fto ? 32'hFFFF_FFFF : frd);
          last_hdr = spi_hdr; last_wdata = spi_wdata;
        end
      end else if (infl) begin
        n_cmp++;
        if ({spi_hdr, spi_wdata} !== fcmd) begin
          n_err++; $display("FAIL hdr_stable: got %h want %h", {spi_hdr, spi_wdata}, fcmd);
        end
        if (!fto) begin
          cnt--;
          if (cnt == 0) begin
            spi_done = 1'b1; spi_rdata = frd;
            infl = 0; done_cyc = cyc; last_end = cyc; n_done++;
          end
        end else if (cyc > start_cyc + TMO) begin
          n_err++; $display("FAIL missing_abort: got none want abort at cyc %0d", start_cyc + TMO);
          infl = 0;
        end
      end
      if (RxFIFO_wr_en) begin
        n_push++; push_cyc = cyc; last_rx = RxFIFO_din; n_cmp += 2;
        if (exp_rx.size() == 0) begin
          n_err++; $display("FAIL unexpected_push: got push %h want none", RxFIFO_din);
        end else begin
          logic [31:0] e;
          e = exp_rx.pop_front();
          if (RxFIFO_din !== e) begin
            n_err++; $display("FAIL rx_data: got %h want %h", RxFIFO_din, e);
          end
        end
        if (full_smp) begin
          n_err++; $display("FAIL push_while_full: got push want hold");
        end
      end
    end
    TxFIFO_empty = (txq.size() == 0);
  end

  task automatic tick(int n = 1);
    repeat (n) @(negedge HCLK);
    #1;
  endtask

  task automatic push_cmd(logic [40:0] c, int d, logic [31:0] r);
    txq.push_back(c); dq.push_back(d); rq.push_back(r);
  endtask

  task automatic wait_quiet(int max);
    int k = 0;
    while (!(!busy && !infl && !pend && isq.size() == 0 && (txq.size() == 0 || !enable)) && k < max) begin
      tick(); k++;
    end
    n_cmp++;
    if (k >= max) begin n_err++; $display("FAIL wait_quiet: got busy after %0d cycles want idle", k); end
  endtask

  task automatic wait_count(string nm, int max, int tgt, int which);
    int k = 0, v;
    v = (which == 0) ? n_start : (which == 1) ? n_done : (which == 2) ? n_abort : (which == 3) ? n_push : n_fetch;
    while (v < tgt && k < max) begin
      tick(); k++;
      v = (which == 0) ? n_start : (which == 1) ? n_done : (which == 2) ? n_abort : (which == 3) ? n_push : n_fetch;
    end
    n_cmp++;
    if (v < tgt) begin n_err++; $display("FAIL wait_%s: got %0d want %0d", nm, v, tgt); end
  endtask

  task automatic test_reset();
    HRESET = 1'b1; enable = 1'b0;
    tick(2);
    n_cmp += 4;
    if ({TxFIFO_rd_en, RxFIFO_wr_en, spi_start, spi_abort, busy, err_timeout} !== 6'b0) begin
      n_err++; $display("FAIL reset_flags: got %b want 0", {TxFIFO_rd_en, RxFIFO_wr_en, spi_start, spi_abort, busy, err_timeout});
    end
    if (spi_hdr !== 9'h0 || spi_wdata !== 32'h0) begin
      n_err++; $display("FAIL reset_frame: got %h %h want 0", spi_hdr, spi_wdata);
    end
    if (RxFIFO_din !== 32'h0) begin n_err++; $display("FAIL reset_din: got %h want 0", RxFIFO_din); end
    if (txn_count !== '0) begin n_err++; $display("FAIL reset_txn: got %0d want 0", txn_count); end
    HRESET = 1'b0;
    tick();
  endtask

  task automatic test_write();
    int s0 = n_start, f0 = n_fetch, p0 = n_push;
    enable = 1'b1;
    push_cmd({1'b1, 1'b1, 7'h12, 32'hA5A5_0001}, 10, 32'h0);
    push_cmd({1'b1, 8'($urandom), $urandom}, 3, 32'h0);
    wait_count("start", 20, s0 + 1, 0);
    n_cmp += 2;
    if (last_hdr !== 9'h192) begin n_err++; $display("FAIL write_hdr: got %h want 192", last_hdr); end
    if (last_wdata !== 32'hA5A5_0001) begin n_err++; $display("FAIL write_wdata: got %h want a5a50001", last_wdata); end
    wait_count("fetch2", 40, f0 + 2, 4);
    n_cmp++;
    if (rd_cyc - done_cyc != GAP + 2) begin
      n_err++; $display("FAIL write_gap: got %0d want %0d", rd_cyc - done_cyc, GAP + 2);
    end
    wait_quiet(100);
    n_cmp += 2;
    if (n_push != p0) begin n_err++; $display("FAIL write_no_push: got %0d pushes want 0", n_push - p0); end
    if (txn_count !== CW'(exp_txn)) begin n_err++; $display("FAIL write_txn: got %0d want %0d", txn_count, CW'(exp_txn)); end
  endtask

  task automatic test_read();
    int p0 = n_push;
    push_cmd({1'b0, 1'b0, 7'h10, 32'h0000_1234}, 6, 32'hCAFE_F00D);
    wait_quiet(100);
    n_cmp += 3;
    if (n_push != p0 + 1) begin n_err++; $display("FAIL read_push_count: got %0d want 1", n_push - p0); end
    if (last_rx !== 32'hCAFE_F00D) begin n_err++; $display("FAIL read_data: got %h want cafef00d", last_rx); end
    if (txn_count !== CW'(exp_txn)) begin n_err++; $display("FAIL read_txn: got %0d want %0d", txn_count, CW'(exp_txn)); end
  endtask

  task automatic test_backpressure();
    int p0 = n_push, f0 = n_fetch, d0 = n_done, f;
    logic [31:0] r = $urandom;
    RxFIFO_full = 1'b1;
    push_cmd({1'b0, 8'($urandom), $urandom}, 3, r);
    push_cmd({1'b1, 8'($urandom), $urandom}, 2, 32'h0);
    wait_count("bp_done", 40, d0 + 1, 1);
    tick(20);
    n_cmp += 3;
    if (n_push != p0) begin n_err++; $display("FAIL bp_no_push: got %0d want 0", n_push - p0); end
    if (n_fetch != f0 + 1) begin n_err++; $display("FAIL bp_no_fetch: got %0d want 1", n_fetch - f0); end
    if (busy !== 1'b1) begin n_err++; $display("FAIL bp_busy: got %b want 1", busy); end
    RxFIFO_full = 1'b0; f = cyc;
    wait_count("bp_push", 5, p0 + 1, 3);
    n_cmp += 2;
    if (push_cyc != f + 1) begin n_err++; $display("FAIL bp_push_time: got %0d want %0d", push_cyc - f, 1); end
    if (last_rx !== r) begin n_err++; $display("FAIL bp_data: got %h want %h", last_rx, r); end
    wait_quiet(100);
  endtask

  task automatic test_timeout();
    int a0 = n_abort, p0 = n_push;
    logic [31:0] r = $urandom;
    push_cmd({1'b0, 8'($urandom), $urandom}, -1, 32'h0);
    wait_count("abort", 40, a0 + 1, 2);
    n_cmp += 2;
    if (abort_cyc - start_cyc != TMO) begin n_err++; $display("FAIL to_latency: got %0d want %0d", abort_cyc - start_cyc, TMO); end
    if (err_timeout !== 1'b1) begin n_err++; $display("FAIL to_err_set: got %b want 1", err_timeout); end
    wait_quiet(100);
    n_cmp += 2;
    if (n_push != p0 + 1) begin n_err++; $display("FAIL to_push_count: got %0d want 1", n_push - p0); end
    if (last_rx !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL to_fill: got %h want ffffffff", last_rx); end
    err_clr = 1'b1; tick(); err_clr = 1'b0; exp_err = 0;
    n_cmp++;
    if (err_timeout !== 1'b0) begin n_err++; $display("FAIL err_clr: got %b want 0", err_timeout); end
    // done on the last watchdog cycle beats the timeout
    push_cmd({1'b0, 8'($urandom), $urandom}, TMO - 1, r);
    wait_quiet(100);
    n_cmp += 3;
    if (n_abort != a0 + 1) begin n_err++; $display("FAIL edge_abort: got %0d aborts want 0", n_abort - a0 - 1); end
    if (err_timeout !== 1'b0) begin n_err++; $display("FAIL edge_err: got %b want 0", err_timeout); end
    if (last_rx !== r) begin n_err++; $display("FAIL edge_data: got %h want %h", last_rx, r); end
    // simultaneous clear and timeout: set wins
    err_clr = 1'b1;
    push_cmd({1'b1, 8'($urandom), $urandom}, -1, 32'h0);
    wait_count("abort2", 40, a0 + 2, 2);
    n_cmp++;
    if (err_timeout !== 1'b1) begin n_err++; $display("FAIL err_prio: got %b want 1", err_timeout); end
    tick();
    n_cmp++;
    if (err_timeout !== 1'b0) begin n_err++; $display("FAIL err_clr_after: got %b want 0", err_timeout); end
    err_clr = 1'b0; exp_err = 0;
    wait_quiet(100);
    n_cmp++;
    if (txn_count !== CW'(exp_txn)) begin n_err++; $display("FAIL to_txn: got %0d want %0d", txn_count, CW'(exp_txn)); end
  endtask

  task automatic test_stream();
    int s0 = n_start;
    for (int i = 0; i < 4; i++) push_cmd({1'b1, 8'($urandom), $urandom}, 5, 32'h0);
    wait_count("stream_start2", 60, s0 + 2, 0);
    enable = 1'b0;
    wait_quiet(100);
    tick(10);
    n_cmp += 3;
    if (n_start != s0 + 2) begin n_err++; $display("FAIL stream_paused: got %0d frames want 2", n_start - s0); end
    if (txq.size() != 2) begin n_err++; $display("FAIL stream_left: got %0d want 2", txq.size()); end
    if (busy !== 1'b0) begin n_err++; $display("FAIL stream_busy: got %b want 0", busy); end
    enable = 1'b1;
    wait_quiet(200);
    n_cmp += 2;
    if (n_start != s0 + 4) begin n_err++; $display("FAIL stream_all: got %0d frames want 4", n_start - s0); end
    if (txn_count !== CW'(exp_txn)) begin n_err++; $display("FAIL stream_txn: got %0d want %0d", txn_count, CW'(exp_txn)); end
  endtask

  task automatic test_reset_mid();
    int s0 = n_start;
    push_cmd({1'b1, 8'($urandom), $urandom}, -1, 32'h0);
    wait_count("rm_start", 20, s0 + 1, 0);
    tick(3);
    HRESET = 1'b1;
    tick();
    n_cmp += 3;
    if ({TxFIFO_rd_en, RxFIFO_wr_en, spi_start, spi_abort, busy, err_timeout} !== 6'b0) begin
      n_err++; $display("FAIL rm_flags: got %b want 0", {TxFIFO_rd_en, RxFIFO_wr_en, spi_start, spi_abort, busy, err_timeout});
    end
    if ({spi_hdr, spi_wdata, RxFIFO_din} !== '0) begin
      n_err++; $display("FAIL rm_data: got %h want 0", {spi_hdr, spi_wdata, RxFIFO_din});
    end
    if (txn_count !== '0) begin n_err++; $display("FAIL rm_txn: got %0d want 0", txn_count); end
    HRESET = 1'b0;
    s0 = n_start;
    tick(30);
    n_cmp++;
    if (n_start != s0) begin n_err++; $display("FAIL rm_spurious: got %0d starts want 0", n_start - s0); end
  endtask

  task automatic test_random();
    int k = 0;
    for (int i = 0; i < 24; i++) begin
      int d = $urandom_range(1, 20);
      push_cmd({1'($urandom), 8'($urandom), $urandom}, d, $urandom);
    end
    while (!(!busy && !infl && !pend && isq.size() == 0 && txq.size() == 0) && k < 3000) begin
      RxFIFO_full = ($urandom_range(0, 3) == 0);
      tick(); k++;
    end
    RxFIFO_full = 1'b0;
    wait_quiet(100);
    n_cmp += 4;
    if (txn_count !== CW'(exp_txn)) begin n_err++; $display("FAIL rand_txn: got %0d want %0d", txn_count, CW'(exp_txn)); end
    if (exp_rx.size() != 0) begin n_err++; $display("FAIL rand_rx_left: got %0d want 0", exp_rx.size()); end
    if (err_timeout !== exp_err) begin n_err++; $display("FAIL rand_err: got %b want %b", err_timeout, exp_err); end
    if (txq.size() != 0) begin n_err++; $display("FAIL rand_txq: got %0d want 0", txq.size()); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_backpressure();
    test_timeout();
    test_stream();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1);
  end
endmodule
